// File: rtl/sqrt_pkg.sv
// Shared encodings for the square-root controller: ALU opcodes, register
// indices of the datapath register file, and the controller state enum.
package sqrt_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b11;

    localparam int unsigned REG_X     = 0;
    localparam int unsigned REG_CNT   = 1;
    localparam int unsigned REG_ODD   = 2;
    localparam int unsigned REG_TWO   = 3;
    localparam int unsigned REG_TRIAL = 4;
    localparam int unsigned REG_ZERO  = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_SIGN,
        S_INIT_CNT,
        S_INIT_ODD,
        S_INIT_TWO,
        S_TRY,
        S_COMMIT,
        S_COUNT,
        S_NEXT_ODD,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_e;

endpackage

// File: rtl/sqrt_controller.sv
// Control FSM computing floor(sqrt(x)) on the external datapath by subtracting
// successive odd numbers; all datapath controls are decoded from state only.
module sqrt_controller
    import sqrt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  negative_i,
    input  logic                  zero_i,
    output logic                  IE_o,
    output logic                  WE_o,
    output logic                  OE_o,
    output logic [ADDR_WIDTH-1:0] ADDR_WR_o,
    output logic [ADDR_WIDTH-1:0] ADDR_RDA_o,
    output logic [ADDR_WIDTH-1:0] ADDR_RDB_o,
    output logic [1:0]            ALU_Op_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  exact_o
);

    // The register map needs indices up to 5 and the sign test needs an MSB.
    if (DATA_WIDTH < 2 || ADDR_WIDTH < 3) begin : g_param_check
        $error("sqrt_controller: unsupported DATA_WIDTH/ADDR_WIDTH");
    end

    state_e state_q, state_d;
    logic   error_q, error_d;
    logic   exact_q, exact_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            error_q <= 1'b0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            exact_q <= exact_d;
        end
    end

    // Flags are only consulted in SIGN and TRY, the cycles that produce them.
    always_comb begin
        state_d = state_q;
        error_d = error_q;
        exact_d = exact_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    error_d = 1'b0;
                    exact_d = 1'b0;
                end
            end
            S_LOAD:     state_d = S_CLR;
            S_CLR:      state_d = S_SIGN;
            S_SIGN: begin
                if (negative_i) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_INIT_CNT;
                    if (zero_i) exact_d = 1'b1;
                end
            end
            S_INIT_CNT: state_d = S_INIT_ODD;
            S_INIT_ODD: state_d = S_INIT_TWO;
            S_INIT_TWO: state_d = S_TRY;
            S_TRY: begin
                if (negative_i) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_COMMIT;
                    if (zero_i) exact_d = 1'b1;
                end
            end
            S_COMMIT:   state_d = S_COUNT;
            S_COUNT:    state_d = S_NEXT_ODD;
            S_NEXT_ODD: state_d = S_TRY;
            S_FINISH:   state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_ERROR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IE_o       = 1'b0;
        WE_o       = 1'b0;
        OE_o       = 1'b0;
        ADDR_WR_o  = '0;
        ADDR_RDA_o = '0;
        ADDR_RDB_o = '0;
        ALU_Op_o   = ALU_ADD;
        done_o     = 1'b0;
        case (state_q)
            S_LOAD: begin
                IE_o      = 1'b1;
                WE_o      = 1'b1;
                ADDR_WR_o = ADDR_WIDTH'(REG_X);
            end
            S_CLR: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_ZERO);
                ADDR_RDA_o = ADDR_WIDTH'(REG_X);
                ADDR_RDB_o = ADDR_WIDTH'(REG_X);
                ALU_Op_o   = ALU_SUB;
            end
            S_SIGN: begin
                ADDR_RDA_o = ADDR_WIDTH'(REG_X);
                ADDR_RDB_o = ADDR_WIDTH'(REG_ZERO);
                ALU_Op_o   = ALU_SUB;
            end
            S_INIT_CNT: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_CNT);
                ADDR_RDA_o = ADDR_WIDTH'(REG_ZERO);
                ADDR_RDB_o = ADDR_WIDTH'(REG_ZERO);
            end
            S_INIT_ODD: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_ODD);
                ADDR_RDA_o = ADDR_WIDTH'(REG_ZERO);
                ALU_Op_o   = ALU_INC;
            end
            S_INIT_TWO: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_TWO);
                ADDR_RDA_o = ADDR_WIDTH'(REG_ODD);
                ALU_Op_o   = ALU_INC;
            end
            S_TRY: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_TRIAL);
                ADDR_RDA_o = ADDR_WIDTH'(REG_X);
                ADDR_RDB_o = ADDR_WIDTH'(REG_ODD);
                ALU_Op_o   = ALU_SUB;
            end
            S_COMMIT: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_X);
                ADDR_RDA_o = ADDR_WIDTH'(REG_TRIAL);
                ADDR_RDB_o = ADDR_WIDTH'(REG_ZERO);
            end
            S_COUNT: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_CNT);
                ADDR_RDA_o = ADDR_WIDTH'(REG_CNT);
                ALU_Op_o   = ALU_INC;
            end
            S_NEXT_ODD: begin
                WE_o       = 1'b1;
                ADDR_WR_o  = ADDR_WIDTH'(REG_ODD);
                ADDR_RDA_o = ADDR_WIDTH'(REG_ODD);
                ADDR_RDB_o = ADDR_WIDTH'(REG_TWO);
            end
            S_FINISH: begin
                OE_o       = 1'b1;
                ADDR_RDA_o = ADDR_WIDTH'(REG_CNT);
                ADDR_RDB_o = ADDR_WIDTH'(REG_ZERO);
            end
            S_DONE:  done_o = 1'b1;
            S_ERROR: done_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign error_o = error_q;
    assign exact_o = exact_q;

endmodule

// File: tb/tb_sqrt_controller.sv
// Scoreboard bench: a behavioural datapath closes the loop around the controller
// and a monitor checks root, flags and latency at every done pulse.
module tb_sqrt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        negative_i;
    logic        zero_i;
    logic        IE_o, WE_o, OE_o;
    logic [2:0]  ADDR_WR_o, ADDR_RDA_o, ADDR_RDB_o;
    logic [1:0]  ALU_Op_o;
    logic        busy_o, done_o, error_o, exact_o;

    logic [31:0] data_i;
    logic [31:0] data_o = 32'd0;
    logic [31:0] rf [8];
    logic [31:0] alu_a, alu_b, alu_res;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          oe_cnt = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] data;
        bit          exact;
        bit          err;
        int unsigned lat;
        int unsigned start_cyc;
        int          oe;
    } exp_t;

    exp_t sb[$];

    sqrt_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .negative_i (negative_i),
        .zero_i     (zero_i),
        .IE_o       (IE_o),
        .WE_o       (WE_o),
        .OE_o       (OE_o),
        .ADDR_WR_o  (ADDR_WR_o),
        .ADDR_RDA_o (ADDR_RDA_o),
        .ADDR_RDB_o (ADDR_RDB_o),
        .ALU_Op_o   (ALU_Op_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .exact_o    (exact_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: register file, ALU, input mux, output register.
    always_comb begin
        alu_a = rf[ADDR_RDA_o];
        alu_b = rf[ADDR_RDB_o];
        case (ALU_Op_o)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b11:   alu_res = alu_a + 32'd1;
            default: alu_res = 32'hBAD0BAD0;
        endcase
        negative_i = alu_res[31];
        zero_i     = (alu_res == 32'd0);
    end

    always @(posedge clk) begin
        if (WE_o) rf[ADDR_WR_o] <= IE_o ? data_i : alu_res;
        if (OE_o) data_o <= alu_res;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (OE_o) oe_cnt++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("data_o x=%0h", e.x), data_o, e.data);
                    chk($sformatf("exact_o x=%0h", e.x), exact_o, e.exact);
                    chk($sformatf("error_o x=%0h", e.x), error_o, e.err);
                    chk($sformatf("latency x=%0h", e.x), cyc - e.start_cyc, e.lat);
                    chk($sformatf("oe_pulses x=%0h", e.x), oe_cnt, e.oe);
                end
                oe_cnt = 0;
            end
        end
    end

    function automatic logic [20:0] all_outs();
        return {IE_o, WE_o, OE_o, ADDR_WR_o, ADDR_RDA_o, ADDR_RDB_o,
                ALU_Op_o, busy_o, done_o, error_o, exact_o};
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] root,
                         input bit exact, input bit err, input int unsigned lat);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1;
        data_i  = x;
        e.x = x; e.data = root; e.exact = exact; e.err = err;
        e.lat = lat; e.start_cyc = cyc; e.oe = err ? 0 : 1;
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        data_i = 32'hA5A5A5A5;
    endtask

    task automatic wait_idle();
        int unsigned budget = 2000;
        while (sb.size() != 0 && budget != 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (sb.size() != 0) begin
            chk("timeout_waiting_done", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int unsigned c0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        data_i  = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;

        issue(32'd0, 32'd0, 1'b1, 1'b0, 9);            wait_idle();
        issue(32'd16, 32'd4, 1'b1, 1'b0, 25);          wait_idle();
        issue(32'd17, 32'd4, 1'b0, 1'b0, 25);          wait_idle();
        issue(32'hFFFFFFF0, 32'd4, 1'b0, 1'b1, 4);     wait_idle();
        @(negedge clk);
        chk("error_held_after_done", error_o, 1);
        chk("idle_after_error", busy_o, 0);
        issue(32'd1, 32'd1, 1'b1, 1'b0, 13);           wait_idle();
        issue(32'd2, 32'd1, 1'b0, 1'b0, 13);           wait_idle();
        issue(32'd99, 32'd9, 1'b0, 1'b0, 45);          wait_idle();
        issue(32'd10000, 32'd100, 1'b1, 1'b0, 409);    wait_idle();
        // back-to-back: next start lands in the IDLE cycle right after DONE
        issue(32'd16, 32'd4, 1'b1, 1'b0, 25);          wait_idle();
        issue(32'd65535, 32'd255, 1'b0, 1'b0, 1029);   wait_idle();

        // abort x=100 with reset in cycle 20
        @(negedge clk);
        c0 = cyc;
        start_i = 1'b1;
        data_i  = 32'd100;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        chk("busy_before_abort", busy_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("outputs_after_abort", all_outs(), 0);
        rst_n = 1'b1;

        // x=9 with a stray start pulse mid-run and another during DONE
        fork
            issue(32'd9, 32'd3, 1'b1, 1'b0, 21);
            begin
                repeat (5) @(negedge clk);
                start_i = 1'b1;
                data_i  = 32'd7;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        wait_idle();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_in_done_ignored", busy_o, 0);
        repeat (3) @(negedge clk);
        chk("still_idle", busy_o, 0);
        chk("data_o_kept", data_o, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
